// File: rtl/muldiv_unit_pkg.sv
// Shared decode constants and FSM state type
// for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; with neg set
// to the operand sign it yields the magnitude.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? -a : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider
// with HI/LO result registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    p_q, p_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic neg_q, neg_d;
    logic nrem_q, nrem_d;
    logic divz_q, divz_d;
    logic isdiv_q, isdiv_d;

    logic dec_mul, dec_div, dec_mthi, dec_mtlo, dec_sgn;
    logic accept, last;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] quot_s, rem_s;
    logic [W2-1:0]    prod_s;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [W2-1:0]    mul_nxt, div_nxt;

    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        dec_sgn  = 1'b0;
        unique case (1'b1)
            (funct == F_MULT):  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            (funct == F_MULTU): dec_mul = 1'b1;
            (funct == F_DIV):   begin dec_div = 1'b1; dec_sgn = 1'b1; end
            (funct == F_DIVU):  dec_div = 1'b1;
            (funct == F_MTHI):  dec_mthi = 1'b1;
            (funct == F_MTLO):  dec_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign accept = (state_q == S_IDLE) && start && !flush;
    assign last   = (cnt_q == CW'(WIDTH - 1));

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .a(srca), .neg(dec_sgn & srca[WIDTH-1]), .y(a_abs));
    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .a(srcb), .neg(dec_sgn & srcb[WIDTH-1]), .y(b_abs));
    muldiv_signfix #(.WIDTH(W2)) u_fix_p (
        .a(p_q), .neg(neg_q), .y(prod_s));
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_q (
        .a(p_q[WIDTH-1:0]), .neg(neg_q), .y(quot_s));
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_r (
        .a(p_q[W2-1:WIDTH]), .neg(nrem_q), .y(rem_s));

    // p_q holds {acc, multiplier} for MUL and {rem, dividend/quot} for DIV
    assign mul_sum = {1'b0, p_q[W2-1:WIDTH]}
                   + (p_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {mul_sum, p_q[WIDTH-1:1]};
    assign div_trial = {p_q[W2-1:WIDTH], p_q[WIDTH-1]}
                     - {1'b0, b_q};
    assign div_nxt = div_trial[WIDTH]
                   ? {p_q[W2-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            nrem_q  <= 1'b0;
            divz_q  <= 1'b0;
            isdiv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            nrem_q  <= nrem_d;
            divz_q  <= divz_d;
            isdiv_q <= isdiv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && dec_mul) state_d = S_MUL;
                else if (accept && dec_div) state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (flush) state_d = S_IDLE;
                else if (last) state_d = S_FIX;
            end
            S_FIX: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        hi   = hi_q;
        lo   = lo_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        nrem_d  = nrem_q;
        divz_d  = divz_q;
        isdiv_d = isdiv_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && (dec_mul || dec_div)) begin
                    cnt_d   = '0;
                    isdiv_d = dec_div;
                    neg_d   = dec_sgn
                            & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    nrem_d  = dec_sgn & srca[WIDTH-1];
                    divz_d  = (srcb == '0);
                    p_d     = {{WIDTH{1'b0}},
                               dec_div ? a_abs : b_abs};
                    b_d     = dec_div ? b_abs : a_abs;
                end
                if (accept && dec_mthi) hi_d = srca;
                if (accept && dec_mtlo) lo_d = srca;
            end
            S_MUL: begin
                p_d   = mul_nxt;
                cnt_d = cnt_q + CW'(1);
            end
            S_DIV: begin
                p_d   = div_nxt;
                cnt_d = cnt_q + CW'(1);
            end
            S_FIX: begin
                if (!flush && isdiv_q) begin
                    hi_d = rem_s;
                    lo_d = divz_q ? '1 : quot_s;
                end else if (!flush) begin
                    hi_d = prod_s[W2-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit at WIDTH=32
// and a WIDTH=8 regression instance.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush;
    logic [5:0]  funct;
    logic [31:0] srca, srcb;
    logic        busy;
    logic [31:0] hi, lo;

    logic        start8;
    logic [5:0]  funct8;
    logic [7:0]  a8, b8;
    logic        busy8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;
    int nb;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .funct(funct), .srca(srca), .srcb(srcb),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .funct(funct8), .srca(a8), .srcb(b8),
        .flush(1'b0), .busy(busy8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, then count negedges with busy high (bounded).
    task automatic run32(input logic [5:0] f,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int n);
        @(negedge clk);
        start = 1'b1; funct = f; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct = '0; srca = '0; srcb = '0;
        start8 = 1'b0; funct8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        reset = 1'b0;

        run32(F_MULT, 32'hFFFFFFFF, 32'h00000002, nb);
        check("mult busy cycles", nb, 33);
        check("mult hi", hi, 32'hFFFFFFFF);
        check("mult lo", lo, 32'hFFFFFFFE);

        run32(F_MULTU, 32'hFFFFFFFF, 32'h00000002, nb);
        check("multu hi", hi, 32'h00000001);
        check("multu lo", lo, 32'hFFFFFFFE);

        run32(F_DIV, 32'hFFFFFFF9, 32'h00000002, nb);
        check("div busy cycles", nb, 33);
        check("div lo", lo, 32'hFFFFFFFD);
        check("div hi", hi, 32'hFFFFFFFF);

        run32(F_DIVU, 32'h00000007, 32'h00000000, nb);
        check("divu0 busy cycles", nb, 33);
        check("divu0 hi", hi, 32'h00000007);
        check("divu0 lo", lo, 32'hFFFFFFFF);

        run32(F_DIV, 32'hFFFFFFF9, 32'h00000000, nb);
        check("div0 neg hi", hi, 32'hFFFFFFF9);
        check("div0 neg lo", lo, 32'hFFFFFFFF);

        run32(F_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
        check("divmin lo", lo, 32'h80000000);
        check("divmin hi", hi, 32'h00000000);

        // MTHI then MTLO back to back; LO holds 0x80000000 before
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; srca = 32'h12345678;
        @(negedge clk);
        check("mthi busy", {31'b0, busy}, 32'h0);
        check("mthi hi", hi, 32'h12345678);
        check("mthi lo kept", lo, 32'h80000000);
        funct = F_MTLO; srca = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo busy", {31'b0, busy}, 32'h0);
        check("mtlo hi kept", hi, 32'h12345678);
        check("mtlo lo", lo, 32'h9ABCDEF0);

        // flush with start in IDLE, and an undecoded funct
        start = 1'b1; flush = 1'b1; funct = F_MTHI; srca = 32'h0BAD0BAD;
        @(negedge clk);
        flush = 1'b0; funct = 6'b100000;
        @(negedge clk);
        start = 1'b0;
        check("flush+start hi", hi, 32'h12345678);
        check("illegal funct busy", {31'b0, busy}, 32'h0);
        check("illegal funct lo", lo, 32'h9ABCDEF0);

        // MULT flushed on busy cycle 10; a start at cycle 3 is ignored
        start = 1'b1; funct = F_MULT; srca = 32'd3; srcb = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1; funct = F_MTHI; srca = 32'h55555555;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy at cycle 10", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'h0);
        check("flush hi kept", hi, 32'h12345678);
        check("flush lo kept", lo, 32'h9ABCDEF0);

        run32(F_MULTU, 32'd3, 32'd5, nb);
        check("post-flush busy cycles", nb, 33);
        check("post-flush hi", hi, 32'h0);
        check("post-flush lo", lo, 32'd15);

        // reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; srca = 32'hCAFE0001;
        @(negedge clk);
        funct = F_DIV; srca = 32'd100; srcb = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset busy", {31'b0, busy}, 32'h1);
        check("pre-reset hi", hi, 32'hCAFE0001);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", {31'b0, busy}, 32'h0);
        check("midreset hi", hi, 32'h0);
        check("midreset lo", lo, 32'h0);

        // WIDTH=8 regression
        start8 = 1'b1; funct8 = F_MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        nb = 0;
        while (busy8 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        check("w8 busy cycles", nb, 9);
        check("w8 hi", {24'b0, hi8}, 32'h000000FE);
        check("w8 lo", {24'b0, lo8}, 32'h00000001);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; SHALL be even and >= 4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  execute-stage valid for a mul/div/move instruction.
REQ-005 funct  in  6  R-type funct field of that instruction.
REQ-006 srca  in  WIDTH  rs operand (multiplicand/dividend, MTHI/MTLO source).
REQ-007 srcb  in  WIDTH  rt operand (multiplier/divisor).
REQ-008 flush  in  1  cancel any in-flight operation.
REQ-009 busy  out  1  operation in progress; the hazard unit stalls MFHI/MFLO and further starts.
REQ-010 hi  out  WIDTH  HI register.
REQ-011 lo  out  WIDTH  LO register.

Function
REQ-012 Decoded functs: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; start with any other funct SHALL be ignored.
REQ-013 States: IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-014 IDLE + start + MULT/MULTU -> MUL; + DIV/DIVU -> DIV; operands and signed flag latched on that edge.
REQ-015 Signed ops SHALL latch operand magnitudes and result signs; unsigned ops latch operands unchanged.
REQ-016 MUL: radix-2 shift-add, exactly WIDTH cycles, 2*WIDTH-bit product, then -> FIX.
REQ-017 DIV: restoring, exactly WIDTH cycles, WIDTH-bit quotient and remainder, then -> FIX.
REQ-018 FIX (1 cycle): negate product if operand signs differ; negate quotient if signs differ; remainder takes dividend sign; write HI/LO; -> IDLE.
REQ-019 MUL result: HI = upper WIDTH bits, LO = lower WIDTH bits; DIV result: LO = quotient, HI = remainder.
REQ-020 busy SHALL be high exactly WIDTH+1 cycles, from the cycle after the accepting edge through FIX; HI/LO update on the edge at which busy falls.
REQ-021 Divisor zero (signed or unsigned): HI = srca as latched, LO = all ones; latency unchanged.
REQ-022 Signed DIV of most-negative by -1: LO = most-negative, HI = 0; no exception.
REQ-023 MTHI/MTLO in IDLE: write srca to HI/LO at that edge; busy stays low; other register unchanged.
REQ-024 start while busy SHALL be ignored; in-flight operation unaffected.
REQ-025 flush in any non-IDLE state -> IDLE next edge; HI/LO unchanged; busy low next cycle.
REQ-026 flush together with start in IDLE: flush wins; nothing accepted or written.
REQ-027 hi/lo SHALL only change at FIX completion, MTHI/MTLO, or reset; no intermediate values visible.

Reset
REQ-028 reset SHALL force state IDLE, busy = 0, hi = 0, lo = 0, and clear the iteration counter and working registers.
REQ-029 reset has priority over flush and start, including mid-operation.

Structure
REQ-030 A shared package SHALL hold the funct constants of REQ-012 and the state enum of REQ-013.
REQ-031 Iteration counter width SHALL be $clog2(WIDTH+1).
REQ-032 Sub-module muldiv_signfix (combinational two's-complement abs/negate, parameterised WIDTH) is the natural split; the rest is one FSM module.

Verification
REQ-033 WIDTH=32, MULT 0xFFFFFFFF x 0x00000002 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0x00000007 / 0x00000000 -> HI=0x00000007, LO=0xFFFFFFFF.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
REQ-036 MULT started, flush asserted on busy cycle 10 -> busy=0 next cycle, HI/LO keep prior values; a second start during busy before flush is ignored.
REQ-037 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> HI/LO hold those values, busy never asserted; reset mid-DIV -> HI=LO=0, busy=0 next cycle.
REQ-038 WIDTH=8 regression: MULTU 0xFF x 0xFF -> HI=0xFE, LO=0x01, busy exactly 9 cycles.
